// File: rtl/alu_writeback_buffer.sv
// In-order writeback FIFO between the ALU and the register file write port.
// Ports: clk/rst, flush, in_* (push side), wb_* (drain side), count; byp_* with ALU_WB_BYPASS_EN.
module alu_writeback_buffer #(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rd,
  input  logic [63:0]      in_data,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [4:0]       wb_rd,
  output logic [63:0]      wb_data,
  output logic [PTR_W:0]   count
`ifdef ALU_WB_BYPASS_EN
  ,
  input  logic [4:0]       byp_rs,
  output logic             byp_hit,
  output logic [63:0]      byp_data
`endif
);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [4:0]       rd_mem_q [DEPTH];
  logic [63:0]      data_mem_q [DEPTH];
  logic             push;
  logic             pop;

  assign in_ready = (count_q != DEPTH[PTR_W:0]);
  assign wb_valid = (count_q != '0);
  assign wb_rd    = rd_mem_q[rd_ptr_q];
  assign wb_data  = data_mem_q[rd_ptr_q];
  assign count    = count_q;

  // x0 writes complete the handshake but never enqueue
  always_comb begin
    push = in_valid && in_ready && !flush && (in_rd != 5'd0);
    pop  = wb_valid && wb_ready && !flush;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage is intentionally left unreset
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      rd_mem_q[wr_ptr_q]   <= in_rd;
      data_mem_q[wr_ptr_q] <= in_data;
    end
  end

`ifdef ALU_WB_BYPASS_EN
  logic [PTR_W-1:0] byp_idx;

  // Walk oldest to youngest so the last match wins
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    byp_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      byp_idx = rd_ptr_q + PTR_W'(i);
      if (((PTR_W+1)'(i) < count_q) && (byp_rs != 5'd0) &&
          (rd_mem_q[byp_idx] == byp_rs)) begin
        byp_hit  = 1'b1;
        byp_data = data_mem_q[byp_idx];
      end
    end
  end
`endif

endmodule
